// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage load/store responder: each 32-bit access becomes two 16-bit async-SRAM cycles, pipeline frozen via ready.
// Optional `MEM_STALL_COUNT_EN adds a free-running stall_cycles counter output.
module mem_stage_sram_ctrl #(
    parameter logic [31:0] ADDR_BASE = 32'd1024,
    parameter int unsigned SRAM_WAIT = 1,
    parameter int unsigned SRAM_AW   = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n
`ifdef MEM_STALL_COUNT_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [2:0] WAIT_LAST = 3'(SRAM_WAIT);

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic        op_wr;
    logic [15:0] data_hi;
    logic [31:0] offset;
    logic        req;
    logic        last;
    logic        active;
    logic        unused_offset_bits;

    assign req    = rd_en | wr_en;
    assign last   = (cnt == WAIT_LAST);
    assign offset = address - ADDR_BASE;
    // Word index is offset[SRAM_AW:2]; the byte lane and wrapped upper bits are dropped.
    assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req)  state_nxt = LOW;
            LOW:     if (last) state_nxt = HIGH;
            HIGH:    if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        active     = (state == LOW) || (state == HIGH);
        sram_dq_oe = active && op_wr;
        sram_we_n  = !(active && op_wr);
        sram_oe_n  = !(active && !op_wr);
        ready      = ((state == IDLE) && !req) || (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            op_wr       <= 1'b0;
            data_hi     <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (req) begin
                        op_wr       <= wr_en;
                        data_hi     <= write_data[31:16];
                        sram_addr   <= {offset[SRAM_AW:2], 1'b0};
                        sram_dq_out <= write_data[15:0];
                    end
                end
                LOW: begin
                    if (last) begin
                        cnt <= '0;
                        // The latched word index lives in sram_addr[SRAM_AW-1:1]; only the half bit flips.
                        sram_addr[0] <= 1'b1;
                        sram_dq_out  <= data_hi;
                        if (!op_wr) read_data[15:0] <= sram_dq_in;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                HIGH: begin
                    if (last) begin
                        cnt <= '0;
                        if (!op_wr) read_data[31:16] <= sram_dq_in;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

`ifdef MEM_STALL_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        stall_cycles <= '0;
        else if (!ready) stall_cycles <= stall_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Self-checking bench for mem_stage_sram_ctrl: two instances (SRAM_WAIT=0 and 1) against a transaction-level model.
`timescale 1ns/1ps
module tb_mem_stage_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en       [2];
    logic        wr_en       [2];
    logic [31:0] address     [2];
    logic [31:0] write_data  [2];
    logic [31:0] read_data   [2];
    logic        ready       [2];
    logic [17:0] sram_addr   [2];
    logic [15:0] sram_dq_out [2];
    logic [15:0] sram_dq_in  [2];
    logic        sram_dq_oe  [2];
    logic        sram_we_n   [2];
    logic        sram_oe_n   [2];
`ifdef MEM_STALL_COUNT_EN
    logic [31:0] stall_cycles [2];
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_mem [int unsigned];
    logic [15:0] env_mem [int unsigned];
    logic [31:0] exp_rd  [2];

    always #5 clk = ~clk;

    mem_stage_sram_ctrl #(.ADDR_BASE(32'd1024), .SRAM_WAIT(0), .SRAM_AW(18)) dut_w0 (
        .clk(clk), .rst(rst), .rd_en(rd_en[0]), .wr_en(wr_en[0]),
        .address(address[0]), .write_data(write_data[0]), .read_data(read_data[0]),
        .ready(ready[0]), .sram_addr(sram_addr[0]), .sram_dq_out(sram_dq_out[0]),
        .sram_dq_in(sram_dq_in[0]), .sram_dq_oe(sram_dq_oe[0]),
        .sram_we_n(sram_we_n[0]), .sram_oe_n(sram_oe_n[0])
`ifdef MEM_STALL_COUNT_EN
        , .stall_cycles(stall_cycles[0])
`endif
    );

    mem_stage_sram_ctrl #(.ADDR_BASE(32'd1024), .SRAM_WAIT(1), .SRAM_AW(18)) dut_w1 (
        .clk(clk), .rst(rst), .rd_en(rd_en[1]), .wr_en(wr_en[1]),
        .address(address[1]), .write_data(write_data[1]), .read_data(read_data[1]),
        .ready(ready[1]), .sram_addr(sram_addr[1]), .sram_dq_out(sram_dq_out[1]),
        .sram_dq_in(sram_dq_in[1]), .sram_dq_oe(sram_dq_oe[1]),
        .sram_we_n(sram_we_n[1]), .sram_oe_n(sram_oe_n[1])
`ifdef MEM_STALL_COUNT_EN
        , .stall_cycles(stall_cycles[1])
`endif
    );

    function automatic int unsigned mkey(input int unsigned d, input logic [17:0] a);
        return (d << 20) | 32'(a);
    endfunction

    function automatic logic [15:0] init_val(input int unsigned key);
        logic [31:0] h;
        h = key * 32'd40503 + 32'h5AC3;
        return h[15:0];
    endfunction

    function automatic logic [15:0] ref_rd(input int unsigned key);
        return ref_mem.exists(key) ? ref_mem[key] : init_val(key);
    endfunction

    function automatic logic [15:0] env_rd(input int unsigned key);
        return env_mem.exists(key) ? env_mem[key] : init_val(key);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural async SRAM: returns data while oe_n is low, stores dq while we_n is low.
    task automatic drive_sram(input int unsigned d);
        if (!sram_oe_n[d]) sram_dq_in[d] = env_rd(mkey(d, sram_addr[d]));
        else               sram_dq_in[d] = 16'($urandom);
        if (!sram_we_n[d] && sram_dq_oe[d]) env_mem[mkey(d, sram_addr[d])] = sram_dq_out[d];
    endtask

    task automatic clear_inputs();
        for (int unsigned d = 0; d < 2; d++) begin
            rd_en[d] = 1'b0;
            wr_en[d] = 1'b0;
        end
    endtask

    task automatic idle(input int unsigned n);
        clear_inputs();
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            for (int unsigned d = 0; d < 2; d++) begin
                drive_sram(d);
                chk("idle_ready", ready[d], 1'b1);
                chk("idle_we_n", sram_we_n[d], 1'b1);
                chk("idle_oe_n", sram_oe_n[d], 1'b1);
            end
            @(posedge clk); #1;
        end
    endtask

    // One request on instance d (SRAM_WAIT = d), checked cycle by cycle from the access timing rules.
    task automatic txn(input int unsigned d, input logic rd, input logic wr,
                       input logic [31:0] addr, input logic [31:0] data, input bit scramble);
        int unsigned w;
        int unsigned lat;
        logic [31:0] word;
        logic [17:0] base;
        logic [17:0] ea;
        bit          is_wr;
        w     = d;
        lat   = 2 * (w + 1) + 1;
        word  = (addr - 32'd1024) >> 2;
        base  = {word[16:0], 1'b0};
        is_wr = wr;
        if (is_wr) begin
            ref_mem[mkey(d, base)]         = data[15:0];
            ref_mem[mkey(d, base + 18'd1)] = data[31:16];
        end else begin
            exp_rd[d] = {ref_rd(mkey(d, base + 18'd1)), ref_rd(mkey(d, base))};
        end
        clear_inputs();
        rd_en[d] = rd;
        wr_en[d] = wr;
        address[d] = addr;
        write_data[d] = data;
        for (int unsigned k = 0; k <= lat; k++) begin
            @(negedge clk);
            drive_sram(d);
            chk("ready", ready[d], (k == lat) ? 1'b1 : 1'b0);
            if (k >= 1 && k < lat) begin
                ea = (k > w + 1) ? base + 18'd1 : base;
                chk("sram_addr", sram_addr[d], ea);
                chk("we_n", sram_we_n[d], is_wr ? 1'b0 : 1'b1);
                chk("oe_n", sram_oe_n[d], is_wr ? 1'b1 : 1'b0);
                chk("dq_oe", sram_dq_oe[d], is_wr ? 1'b1 : 1'b0);
                if (is_wr) chk("dq_out", sram_dq_out[d], (k > w + 1) ? data[31:16] : data[15:0]);
            end else begin
                chk("we_n_quiet", sram_we_n[d], 1'b1);
                chk("oe_n_quiet", sram_oe_n[d], 1'b1);
                chk("dq_oe_quiet", sram_dq_oe[d], 1'b0);
            end
            if (k == lat) begin
                chk("read_data", read_data[d], exp_rd[d]);
                chk("addr_hold", sram_addr[d], base + 18'd1);
            end
            @(posedge clk); #1;
            if (k == 0 && scramble) begin
                address[d] = $urandom;
                write_data[d] = $urandom;
            end
        end
    endtask

    int unsigned rd_d;
    int unsigned op;
    logic [31:0] raddr;

    initial begin
        rst = 1'b1;
        for (int unsigned d = 0; d < 2; d++) begin
            rd_en[d] = 1'b0;
            wr_en[d] = 1'b0;
            address[d] = '0;
            write_data[d] = '0;
            sram_dq_in[d] = '0;
            exp_rd[d] = '0;
        end
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        for (int unsigned d = 0; d < 2; d++) begin
            chk("rst_read_data", read_data[d], 32'h0);
            chk("rst_sram_addr", sram_addr[d], 18'h0);
            chk("rst_dq_out", sram_dq_out[d], 16'h0);
            chk("rst_dq_oe", sram_dq_oe[d], 1'b0);
            chk("rst_we_n", sram_we_n[d], 1'b1);
            chk("rst_oe_n", sram_oe_n[d], 1'b1);
            chk("rst_ready", ready[d], 1'b1);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);

        txn(1, 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0);
        idle(2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        idle(1);

        txn(1, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
        chk("load_deadbeef", read_data[1], 32'hDEADBEEF);
        txn(1, 1'b0, 1'b1, 32'd1040, 32'hCAFE_F00D, 1'b0);
        idle(1);
`ifdef MEM_STALL_COUNT_EN
        chk("stall_cycles", stall_cycles[1], 32'd10);
`endif

        txn(1, 1'b0, 1'b1, 32'd1020, 32'h0BAD_1DEA, 1'b0);
        txn(1, 1'b1, 1'b0, 32'd1023, 32'h0, 1'b0);
        txn(1, 1'b1, 1'b1, 32'd1100, 32'h1357_9BDF, 1'b0);
        txn(0, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
        txn(0, 1'b0, 1'b1, 32'd1048, 32'hA5A5_5A5A, 1'b0);
        txn(0, 1'b1, 1'b0, 32'd1050, 32'h0, 1'b0);
        idle(1);

        for (int unsigned t = 0; t < 60; t++) begin
            rd_d = $urandom_range(0, 1);
            op = $urandom_range(1, 3);
            raddr = 32'd1024 + (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0)
                raddr = 32'd1024 - (32'($urandom_range(1, 4)) << 2) + 32'($urandom_range(0, 3));
            txn(rd_d, op[0], op[1], raddr, $urandom, 1'b1);
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(1);

        txn(1, 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
        clear_inputs();
        wr_en[1] = 1'b1;
        address[1] = 32'd1424;
        write_data[1] = 32'h1234_5678;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_pre_we_n", sram_we_n[1], 1'b0);
        #1;
        rst = 1'b1;
        wr_en[1] = 1'b0;
        #1;
        chk("rst_mid_we_n", sram_we_n[1], 1'b1);
        chk("rst_mid_dq_oe", sram_dq_oe[1], 1'b0);
        chk("rst_mid_ready", ready[1], 1'b1);
        chk("rst_mid_read_data", read_data[1], 32'h0);
        chk("rst_mid_sram_addr", sram_addr[1], 18'h0);
`ifdef MEM_STALL_COUNT_EN
        chk("rst_mid_stall", stall_cycles[1], 32'h0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        idle(2);
        txn(1, 1'b1, 1'b0, 32'd1040, 32'h0, 1'b0);
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
